led_blink_sched: RTL and testbench

- Two-channel blink scheduler. Generates two square-wave LED outputs from one system clock.
- Each channel toggles after a programmable half-period in clock cycles, with a glitch-free runtime reload handshake.
- Replaces free-running per-LED clocks with one clocked controller. Sits between a simple config master and the LED pins.

---
 rtl/led_blink_sched_if.sv | 24 ++
 rtl/led_blink_sched.sv | 160 ++++++++++++++++
 tb/tb_led_blink_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_blink_sched_if.sv
// Config write channel for led_blink_sched: valid/ready handshake carrying a
// channel select and a new half-period in clock cycles.
interface led_blink_sched_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_sel;
  logic [CNT_W-1:0] cfg_half;

  modport master (
    output cfg_valid,
    output cfg_sel,
    output cfg_half,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_sel,
    input  cfg_half,
    output cfg_ready
  );
endinterface

// File: rtl/led_blink_sched.sv
// Two-channel LED blink scheduler. Each channel toggles its LED every h clock
// cycles while running. Half-periods are reloaded through a valid/ready
// handshake: in IDLE they are written directly, in RUN they are held pending
// and applied at that channel's next toggle so no half-period is cut short.
// Optional build macro LED_PHASE_SYNC_EN: any pending reload applied in RUN
// also restarts both channels phase-aligned (counters 0, LEDs 0).
module led_blink_sched #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DEF_HALF1 = 1,
  parameter int unsigned DEF_HALF2 = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_run,
  led_blink_sched_if.slave  cfg,
  output logic              o_led1,
  output logic              o_led2,
  output logic              o_tick1,
  output logic              o_tick2
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           r_state;
  state_e           w_state_next;

  // Per-channel state; index 0 is channel 1, index 1 is channel 2.
  logic [CNT_W-1:0] r_half [2];
  logic [CNT_W-1:0] r_cnt  [2];
  logic [CNT_W-1:0] r_pend [2];
  logic [1:0]       r_led;
  logic [1:0]       r_tick;
  logic [1:0]       r_pf;

  logic [CNT_W-1:0] w_half_n [2];
  logic [CNT_W-1:0] w_cnt_n  [2];
  logic [CNT_W-1:0] w_pend_n [2];
  logic [1:0]       w_led_n;
  logic [1:0]       w_tick_n;
  logic [1:0]       w_pf_n;

  logic             w_fire;
  logic [1:0]       w_wr;
  logic [1:0]       w_wrap;
  logic [CNT_W-1:0] w_half_cap;

  // A channel with a reload still pending back-pressures only itself while running.
  assign cfg.cfg_ready = (r_state == StIdle) | ~r_pf[cfg.cfg_sel];
  assign w_fire        = cfg.cfg_valid & cfg.cfg_ready;
  assign w_wr          = {w_fire & cfg.cfg_sel, w_fire & ~cfg.cfg_sel};
  assign w_half_cap    = (cfg.cfg_half == '0) ? CNT_W'(1) : cfg.cfg_half;

  // End of half-period detect; h is never 0 so h-1 cannot underflow.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_wrap[i] = (r_cnt[i] == (r_half[i] - CNT_W'(1)));
    end
  end

  // FSM next-state: run level moves between IDLE and RUN.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_run)  w_state_next = StRun;
      StRun:   if (!i_run) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath next-state for counters, LEDs, ticks and reload bookkeeping.
  always_comb begin
    w_half_n = r_half;
    w_cnt_n  = r_cnt;
    w_pend_n = r_pend;
    w_led_n  = r_led;
    w_pf_n   = r_pf;
    w_tick_n = 2'b00;
    if (r_state == StIdle) begin
      for (int i = 0; i < 2; i++) begin
        if (w_wr[i]) w_half_n[i] = w_half_cap;
      end
    end else if (!i_run) begin
      // Leaving RUN: stop cleanly and commit any reload, including one
      // accepted on this very edge.
      for (int i = 0; i < 2; i++) begin
        w_cnt_n[i] = '0;
        w_led_n[i] = 1'b0;
        w_pf_n[i]  = 1'b0;
        if (r_pf[i]) w_half_n[i] = r_pend[i];
        if (w_wr[i]) w_half_n[i] = w_half_cap;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_wrap[i]) begin
          w_cnt_n[i]  = '0;
          w_led_n[i]  = ~r_led[i];
          w_tick_n[i] = 1'b1;
          if (r_pf[i]) begin
            w_half_n[i] = r_pend[i];
            w_pf_n[i]   = 1'b0;
          end
        end else begin
          w_cnt_n[i] = r_cnt[i] + CNT_W'(1);
        end
        // ready excludes pf=1 here, so this never collides with the apply above.
        if (w_wr[i]) begin
          w_pend_n[i] = w_half_cap;
          w_pf_n[i]   = 1'b1;
        end
      end
`ifdef LED_PHASE_SYNC_EN
      if (|(w_wrap & r_pf)) begin
        for (int i = 0; i < 2; i++) begin
          w_cnt_n[i]  = '0;
          w_led_n[i]  = 1'b0;
          w_tick_n[i] = r_led[i];
        end
      end
`else
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Channel state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_half[0] <= CNT_W'(DEF_HALF1);
      r_half[1] <= CNT_W'(DEF_HALF2);
      r_cnt[0]  <= '0;
      r_cnt[1]  <= '0;
      r_pend[0] <= '0;
      r_pend[1] <= '0;
      r_led     <= 2'b00;
      r_tick    <= 2'b00;
      r_pf      <= 2'b00;
    end else begin
      r_half <= w_half_n;
      r_cnt  <= w_cnt_n;
      r_pend <= w_pend_n;
      r_led  <= w_led_n;
      r_tick <= w_tick_n;
      r_pf   <= w_pf_n;
    end
  end

  assign o_led1  = r_led[0];
  assign o_led2  = r_led[1];
  assign o_tick1 = r_tick[0];
  assign o_tick2 = r_tick[1];

endmodule

// File: tb/tb_led_blink_sched.sv
// Directed self-checking bench for led_blink_sched (default build).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_blink_sched;

  logic clk;
  logic rst_n;
  logic run;
  logic led1;
  logic led2;
  logic tick1;
  logic tick2;

  int n_tests;
  int n_fail;

  led_blink_sched_if #(.CNT_W(16)) cfg_if ();

  led_blink_sched #(
    .CNT_W     (16),
    .DEF_HALF1 (1),
    .DEF_HALF2 (2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_run   (run),
    .cfg     (cfg_if.slave),
    .o_led1  (led1),
    .o_led2  (led2),
    .o_tick1 (tick1),
    .o_tick2 (tick2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive-only: reset the DUT, return on a falling edge with reset released.
  task automatic apply_reset();
    rst_n = 1'b0;
    run = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_sel = 1'b0;
    cfg_if.cfg_half = 16'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_sel = 1'b0;
    cfg_if.cfg_half = 16'd0;
    #1;
    n_tests++;
    if ({led1, led2, tick1, tick2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000", {led1, led2, tick1, tick2});
    end
    n_tests++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", cfg_if.cfg_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_default_blink();
    logic [7:0] e_l1;
    logic [7:0] e_l2;
    logic [7:0] e_t1;
    logic [7:0] e_t2;
    int c1;
    int c2;
    e_l1 = 8'b01010101;
    e_l2 = 8'b01100110;
    e_t1 = 8'b11111111;
    e_t2 = 8'b10101010;
    c1 = 0;
    c2 = 0;
    apply_reset();
    run = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({led1, led2, tick1, tick2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL blink_entry: got %b expected 0000", {led1, led2, tick1, tick2});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      c1 += int'(tick1);
      c2 += int'(tick2);
      n_tests++;
      if ({led1, led2, tick1, tick2} !== {e_l1[i], e_l2[i], e_t1[i], e_t2[i]}) begin
        n_fail++;
        $display("FAIL blink_cycle%0d: got %b expected %b", i + 1,
                 {led1, led2, tick1, tick2}, {e_l1[i], e_l2[i], e_t1[i], e_t2[i]});
      end
    end
    n_tests++;
    if (c1 != 8 || c2 != 4) begin
      n_fail++;
      $display("FAIL blink_tick_count: got %0d/%0d expected 8/4", c1, c2);
    end
    run = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({led1, led2, tick1, tick2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL blink_stop: got %b expected 0000", {led1, led2, tick1, tick2});
    end
  endtask

  task automatic test_idle_write();
    logic [8:0] e_l1;
    logic [8:0] e_t1;
    e_l1 = 9'b100011100;
    e_t1 = 9'b100100100;
    apply_reset();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel = 1'b0;
    cfg_if.cfg_half = 16'd3;
    #1;
    n_tests++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: got %b expected 1", cfg_if.cfg_ready);
    end
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    n_tests++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready_after: got %b expected 1", cfg_if.cfg_ready);
    end
    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_tests++;
      if ({led1, tick1} !== {e_l1[i], e_t1[i]}) begin
        n_fail++;
        $display("FAIL idle_write_cycle%0d: got %b expected %b", i + 1,
                 {led1, tick1}, {e_l1[i], e_t1[i]});
      end
    end
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_run_reload();
    logic [13:0] e_l2;
    logic [13:0] e_t2;
    e_l2 = 14'b01111100000110;
    e_t2 = 14'b10000100001010;
    apply_reset();
    run = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 3) cfg_if.cfg_valid = 1'b0;
      n_tests++;
      if ({led2, tick2} !== {e_l2[i-1], e_t2[i-1]}) begin
        n_fail++;
        $display("FAIL reload_cycle%0d: got %b expected %b", i,
                 {led2, tick2}, {e_l2[i-1], e_t2[i-1]});
      end
      if (i == 2) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_sel = 1'b1;
        cfg_if.cfg_half = 16'd5;
        #1;
        n_tests++;
        if (cfg_if.cfg_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL reload_ready_before: got %b expected 1", cfg_if.cfg_ready);
        end
      end
      if (i == 3) begin
        cfg_if.cfg_sel = 1'b1;
        #1;
        n_tests++;
        if (cfg_if.cfg_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL reload_ready_ch2_pending: got %b expected 0", cfg_if.cfg_ready);
        end
        cfg_if.cfg_sel = 1'b0;
        #1;
        n_tests++;
        if (cfg_if.cfg_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL reload_ready_ch1_free: got %b expected 1", cfg_if.cfg_ready);
        end
        cfg_if.cfg_sel = 1'b1;
      end
      if (i == 4) begin
        n_tests++;
        if (cfg_if.cfg_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL reload_ready_after_apply: got %b expected 1", cfg_if.cfg_ready);
        end
      end
    end
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_same_edge();
    logic [6:0] e_l2;
    e_l2 = 7'b1000110;
    apply_reset();
    run = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 2) cfg_if.cfg_valid = 1'b0;
      n_tests++;
      if (led2 !== e_l2[i-1]) begin
        n_fail++;
        $display("FAIL same_edge_cycle%0d: got %b expected %b", i, led2, e_l2[i-1]);
      end
      if (i == 1) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_sel = 1'b1;
        cfg_if.cfg_half = 16'd3;
      end
      if (i == 2) begin
        #1;
        n_tests++;
        if (cfg_if.cfg_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL same_edge_ready: got %b expected 0", cfg_if.cfg_ready);
        end
      end
    end
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clamp();
    logic [3:0] e_l1;
    e_l1 = 4'b0101;
    apply_reset();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel = 1'b0;
    cfg_if.cfg_half = 16'd3;
    @(negedge clk);
    cfg_if.cfg_half = 16'd0;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if ({led1, tick1} !== {e_l1[i], 1'b1}) begin
        n_fail++;
        $display("FAIL clamp_cycle%0d: got %b expected %b", i + 1, {led1, tick1}, {e_l1[i], 1'b1});
      end
    end
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_run_drop();
    logic [7:0] e_l2;
    e_l2 = 8'b11000000;
    apply_reset();
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel = 1'b1;
    cfg_if.cfg_half = 16'd7;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    n_tests++;
    if ({led1, led2, cfg_if.cfg_ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL drop_before: got %b expected 110", {led1, led2, cfg_if.cfg_ready});
    end
    run = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({led1, led2, tick1, tick2, cfg_if.cfg_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL drop_idle: got %b expected 00001",
               {led1, led2, tick1, tick2, cfg_if.cfg_ready});
    end
    @(negedge clk);
    n_tests++;
    if ({led1, led2, tick1, tick2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL drop_idle_hold: got %b expected 0000", {led1, led2, tick1, tick2});
    end
    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      if (led2 !== e_l2[i]) begin
        n_fail++;
        $display("FAIL drop_rerun_cycle%0d: got %b expected %b", i + 1, led2, e_l2[i]);
      end
    end
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    apply_reset();
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({led1, tick1} !== 2'b11) begin
      n_fail++;
      $display("FAIL async_pre: got %b expected 11", {led1, tick1});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({led1, led2, tick1, tick2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected 0000", {led1, led2, tick1, tick2});
    end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    run = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_sel = 1'b0;
    cfg_if.cfg_half = 16'd0;
    test_reset();
    test_default_blink();
    test_idle_write();
    test_run_reload();
    test_same_edge();
    test_clamp();
    test_run_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
